// File: rtl/cl_tcdm_arb_pkg.sv
// -----------------------------------------------------------------------------
// cl_tcdm_arb_pkg
// Shared helpers for the cluster TCDM round-robin arbiter.
//   idx_width()      : bits needed to index n items (never less than 1)
//   outst_is_legal() : outstanding-request depth is >= 1 and a power of two
// -----------------------------------------------------------------------------
package cl_tcdm_arb_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit outst_is_legal(input int unsigned m);
        return (m >= 1) && ((m & (m - 1)) == 0);
    endfunction

endpackage

// File: rtl/cl_tcdm_id_fifo.sv
// -----------------------------------------------------------------------------
// cl_tcdm_id_fifo
// Small synchronous FIFO holding the requester index of every accepted TCDM
// request, so responses can be routed back in issue order.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/data_i : enqueue data_i (ignored while full)
//   pop_i         : dequeue the head (ignored while empty)
//   full_o        : DEPTH entries stored
//   empty_o       : no entries stored
//   head_o        : oldest entry (stale while empty)
// -----------------------------------------------------------------------------
module cl_tcdm_id_fifo
    import cl_tcdm_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = idx_width(DEPTH);
    localparam int unsigned CNT_W = idx_width(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        // NOTE: every variable gets its default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        // Explicit wrap keeps the pointers correct even for DEPTH == 1.
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        // Push and pop in the same cycle leave the occupancy unchanged.
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only ever
    // read after it was written, which the reset occupancy already guarantees.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cl_tcdm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cl_tcdm_rr_arbiter
// Round-robin arbiter sharing one cluster TCDM master port between NB_REQ
// requesters. Accepted requests record their requester index in an in-order
// ID FIFO so each response beat is routed back to its issuer. A request that
// was offered but not granted stays locked to its winner until granted.
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   req_i/add_i/wen_i/data_i/be_i : per-requester TCDM request (wen 1 = read)
//   gnt_o                      : per-requester grant
//   r_valid_o                  : per-requester response valid
//   r_data_o                   : response data, shared by all requesters
//   req_o/add_o/wen_o/data_o/be_o : master-side request
//   gnt_i, r_valid_i, r_data_i : master grant and response
//   busy_o                     : outstanding responses or pending requests
// -----------------------------------------------------------------------------
module cl_tcdm_rr_arbiter
    import cl_tcdm_arb_pkg::*;
#(
    parameter int unsigned NB_REQ     = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NB_REQ-1:0]                      req_i,
    input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]      add_i,
    input  logic [NB_REQ-1:0]                      wen_i,
    input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]      data_i,
    input  logic [NB_REQ-1:0][DATA_WIDTH/8-1:0]    be_i,
    output logic [NB_REQ-1:0]                      gnt_o,
    output logic [NB_REQ-1:0]                      r_valid_o,
    output logic [DATA_WIDTH-1:0]                  r_data_o,
    output logic                                   req_o,
    output logic [ADDR_WIDTH-1:0]                  add_o,
    output logic                                   wen_o,
    output logic [DATA_WIDTH-1:0]                  data_o,
    output logic [DATA_WIDTH/8-1:0]                be_o,
    input  logic                                   gnt_i,
    input  logic                                   r_valid_i,
    input  logic [DATA_WIDTH-1:0]                  r_data_i,
    output logic                                   busy_o
);

    localparam int unsigned IDX_W = idx_width(NB_REQ);

    if (NB_REQ < 2) begin : g_bad_nb_req
        $error("cl_tcdm_rr_arbiter: NB_REQ must be at least 2");
    end
    if (!outst_is_legal(MAX_OUTST)) begin : g_bad_max_outst
        $error("cl_tcdm_rr_arbiter: MAX_OUTST must be >= 1 and a power of two");
    end

    logic [IDX_W-1:0] rr_q, rr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lidx_q, lidx_d;

    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   scan_sum;
    logic [IDX_W-1:0] scan_idx;
    logic             handshake;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [IDX_W-1:0] fifo_head;

    // Winner selection: a locked winner is kept; otherwise scan upward from
    // the round-robin pointer, wrapping at NB_REQ-1 (NB_REQ need not be 2^n).
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (lock_q) begin
            win_valid = req_i[lidx_q];
            win_idx   = lidx_q;
        end else begin
            for (int unsigned i = 0; i < NB_REQ; i++) begin
                scan_sum = {1'b0, rr_q} + (IDX_W + 1)'(i);
                if (scan_sum >= (IDX_W + 1)'(NB_REQ)) begin
                    scan_sum = scan_sum - (IDX_W + 1)'(NB_REQ);
                end
                scan_idx = scan_sum[IDX_W-1:0];
                if (!win_valid && req_i[scan_idx]) begin
                    win_valid = 1'b1;
                    win_idx   = scan_idx;
                end
            end
        end
    end

    // Forwarding and grant. The full check uses the registered occupancy, so
    // a pop in the same cycle does not release the stall until the next one.
    always_comb begin
        req_o  = win_valid & ~fifo_full;
        add_o  = '0;
        wen_o  = 1'b0;
        data_o = '0;
        be_o   = '0;
        if (win_valid) begin
            add_o  = add_i[win_idx];
            wen_o  = wen_i[win_idx];
            data_o = data_i[win_idx];
            be_o   = be_i[win_idx];
        end
        handshake      = req_o & gnt_i;
        gnt_o          = '0;
        gnt_o[win_idx] = handshake;
    end

    // Pointer and lock update.
    always_comb begin
        rr_d   = rr_q;
        lock_d = lock_q;
        lidx_d = lidx_q;
        if (handshake) begin
            rr_d   = (win_idx == IDX_W'(NB_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            lock_d = 1'b0;
        end else if (req_o) begin
            lock_d = 1'b1;
            lidx_d = win_idx;
        end else if (lock_q && !win_valid) begin
            // A locked requester that withdrew must not starve the others.
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            lidx_q <= lidx_d;
        end
    end

    // Response routing: beats arriving with no outstanding entry are dropped.
    assign fifo_pop = r_valid_i & ~fifo_empty;

    always_comb begin
        r_valid_o            = '0;
        r_valid_o[fifo_head] = fifo_pop;
    end

    assign r_data_o = r_data_i;
    assign busy_o   = ~fifo_empty | (|req_i);

    cl_tcdm_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDX_W)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (win_idx),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // A response with nothing outstanding is a master-side protocol error.
    always_ff @(posedge clk_i) begin
        if (rst_ni && r_valid_i) begin
            assert (!fifo_empty)
            else $error("cl_tcdm_rr_arbiter: r_valid_i with no outstanding request");
        end
    end

endmodule

// File: tb/tb_cl_tcdm_rr_arbiter.sv
module tb_cl_tcdm_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 2;

    typedef logic [0:0] idx_t;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [N-1:0]          req_i;
    logic [N-1:0][AW-1:0]  add_i;
    logic [N-1:0]          wen_i;
    logic [N-1:0][DW-1:0]  data_i;
    logic [N-1:0][BW-1:0]  be_i;
    logic [N-1:0]          gnt_o;
    logic [N-1:0]          r_valid_o;
    logic [DW-1:0]         r_data_o;
    logic                  req_o;
    logic [AW-1:0]         add_o;
    logic                  wen_o;
    logic [DW-1:0]         data_o;
    logic [BW-1:0]         be_o;
    logic                  gnt_i;
    logic                  r_valid_i;
    logic [DW-1:0]         r_data_i;
    logic                  busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: pointer, lock and the issue-order queue of ids.
    int rr_m;
    bit lock_m;
    int lidx_m;
    int q_m[$];

    always #5 clk = ~clk;

    cl_tcdm_rr_arbiter #(
        .NB_REQ     (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_OUTST  (MO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .add_i     (add_i),
        .wen_i     (wen_i),
        .data_i    (data_i),
        .be_i      (be_i),
        .gnt_o     (gnt_o),
        .r_valid_o (r_valid_o),
        .r_data_o  (r_data_o),
        .req_o     (req_o),
        .add_o     (add_o),
        .wen_o     (wen_o),
        .data_o    (data_o),
        .be_o      (be_o),
        .gnt_i     (gnt_i),
        .r_valid_i (r_valid_i),
        .r_data_i  (r_data_i),
        .busy_o    (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            add_i[i]  = $urandom;
            data_i[i] = $urandom;
            be_i[i]   = BW'($urandom);
            wen_i[i]  = 1'($urandom);
        end
        r_data_i = $urandom;
    endtask

    // Inputs are applied 1 time unit after the rising edge; outputs are
    // sampled at the falling edge.
    task automatic settle();
        #4;
    endtask

    // Compare every output with the model, advance the model, move to the
    // next cycle.
    task automatic finish_cycle(input string tag);
        int            w;
        bit            exp_req;
        logic [AW-1:0] exp_add;
        logic          exp_wen;
        logic [DW-1:0] exp_data;
        logic [BW-1:0] exp_be;
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  exp_rv;
        bit            exp_busy;

        w = -1;
        if (lock_m) begin
            if (req_i[idx_t'(lidx_m)]) w = lidx_m;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr_m + k) % N;
                if (w < 0 && req_i[idx_t'(c)]) w = c;
            end
        end

        exp_req  = (w >= 0) && (q_m.size() < MO);
        exp_add  = '0;
        exp_wen  = 1'b0;
        exp_data = '0;
        exp_be   = '0;
        if (w >= 0) begin
            exp_add  = add_i[idx_t'(w)];
            exp_wen  = wen_i[idx_t'(w)];
            exp_data = data_i[idx_t'(w)];
            exp_be   = be_i[idx_t'(w)];
        end
        exp_gnt = '0;
        if (exp_req && gnt_i) exp_gnt[idx_t'(w)] = 1'b1;
        exp_rv = '0;
        if (r_valid_i && q_m.size() > 0) exp_rv[idx_t'(q_m[0])] = 1'b1;
        exp_busy = (q_m.size() > 0) || (req_i != '0);

        check({tag, ".req_o"},     64'(req_o),     64'(exp_req));
        check({tag, ".add_o"},     64'(add_o),     64'(exp_add));
        check({tag, ".wen_o"},     64'(wen_o),     64'(exp_wen));
        check({tag, ".data_o"},    64'(data_o),    64'(exp_data));
        check({tag, ".be_o"},      64'(be_o),      64'(exp_be));
        check({tag, ".gnt_o"},     64'(gnt_o),     64'(exp_gnt));
        check({tag, ".r_valid_o"}, 64'(r_valid_o), 64'(exp_rv));
        check({tag, ".r_data_o"},  64'(r_data_o),  64'(r_data_i));
        check({tag, ".busy_o"},    64'(busy_o),    64'(exp_busy));

        if (!rst_ni) begin
            rr_m   = 0;
            lock_m = 1'b0;
            lidx_m = 0;
            q_m.delete();
        end else begin
            if (r_valid_i && q_m.size() > 0) void'(q_m.pop_front());
            if (exp_req && gnt_i) begin
                q_m.push_back(w);
                rr_m   = (w + 1) % N;
                lock_m = 1'b0;
            end else if (exp_req) begin
                lock_m = 1'b1;
                lidx_m = w;
            end else if (lock_m && w < 0) begin
                lock_m = 1'b0;
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string tag);
        settle();
        finish_cycle(tag);
    endtask

    initial begin
        rst_ni    = 1'b0;
        req_i     = '0;
        gnt_i     = 1'b0;
        r_valid_i = 1'b0;
        add_i     = '0;
        wen_i     = '0;
        data_i    = '0;
        be_i      = '0;
        r_data_i  = '0;
        rr_m      = 0;
        lock_m    = 1'b0;
        lidx_m    = 0;
        @(posedge clk);
        #1;

        // Reset values, and a stray beat while reset is held is dropped.
        settle();
        check("rst_req_o", 64'(req_o), 64'd0);
        check("rst_busy_o", 64'(busy_o), 64'd0);
        finish_cycle("rst");
        r_valid_i = 1'b1;
        settle();
        check("rst_stray_rvalid", 64'(r_valid_o), 64'd0);
        finish_cycle("rst_rv");

        // Idle, then requester 1 rises: busy in the same cycle.
        rst_ni    = 1'b1;
        r_valid_i = 1'b0;
        settle();
        check("idle_busy", 64'(busy_o), 64'd0);
        finish_cycle("idle");
        add_i[1] = 32'h1111_0000;
        add_i[0] = 32'h0000_2222;
        req_i    = 2'b10;
        settle();
        check("idle_busy_rise", 64'(busy_o), 64'd1);
        finish_cycle("lock_a");
        cycle("lock_b");
        cycle("lock_c");

        // Requester 0 joins while 1 is locked.
        req_i = 2'b11;
        settle();
        check("lock_add", 64'(add_o), 64'h1111_0000);
        finish_cycle("lock_d");
        gnt_i = 1'b1;
        settle();
        check("lock_gnt", 64'(gnt_o), 64'b10);
        finish_cycle("lock_e");
        r_valid_i = 1'b1;
        settle();
        check("after_lock_gnt", 64'(gnt_o), 64'b01);
        check("after_lock_rvalid", 64'(r_valid_o), 64'b10);
        finish_cycle("lock_f");

        // Alternating grants, each response one cycle after its grant.
        for (int k = 0; k < 8; k++) begin
            rand_fields();
            req_i     = 2'b11;
            gnt_i     = 1'b1;
            r_valid_i = 1'b1;
            settle();
            check("alt_gnt", 64'(gnt_o), (k % 2 == 0) ? 64'b10 : 64'b01);
            check("alt_rvalid", 64'(r_valid_o), (k % 2 == 0) ? 64'b01 : 64'b10);
            finish_cycle("alt");
        end

        // Drain.
        req_i = '0;
        gnt_i = 1'b0;
        for (int i = 0; i < 4 && q_m.size() > 0; i++) begin
            r_valid_i = 1'b1;
            cycle("drain");
        end
        r_valid_i = 1'b0;

        // Full stall with two outstanding requests.
        req_i = 2'b01;
        gnt_i = 1'b1;
        cycle("full_a");
        cycle("full_b");
        settle();
        check("full_req_o", 64'(req_o), 64'd0);
        check("full_gnt", 64'(gnt_o), 64'd0);
        finish_cycle("full_c");
        r_valid_i = 1'b1;
        settle();
        check("full_pop_req_o", 64'(req_o), 64'd0);
        check("full_pop_rvalid", 64'(r_valid_o), 64'b01);
        finish_cycle("full_d");
        settle();
        check("full_release_req_o", 64'(req_o), 64'd1);
        finish_cycle("full_e");

        // Push and pop every cycle at occupancy 1.
        for (int k = 0; k < 10; k++) begin
            rand_fields();
            req_i     = 2'b11;
            gnt_i     = 1'b1;
            r_valid_i = 1'b1;
            settle();
            check("pushpop_req_o", 64'(req_o), 64'd1);
            finish_cycle("pushpop");
        end

        // Reset with two outstanding requests.
        r_valid_i = 1'b0;
        cycle("pre_rst");
        req_i = '0;
        gnt_i = 1'b0;
        rst_ni = 1'b0;
        settle();
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        finish_cycle("mid_rst_a");
        r_valid_i = 1'b1;
        settle();
        check("mid_rst_rvalid", 64'(r_valid_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        finish_cycle("mid_rst_b");
        rst_ni    = 1'b1;
        r_valid_i = 1'b0;
        req_i     = 2'b11;
        add_i[0]  = 32'hCAFE_0000;
        add_i[1]  = 32'h0000_BEEF;
        settle();
        check("post_rst_req_o", 64'(req_o), 64'd1);
        check("post_rst_add", 64'(add_o), 64'hCAFE_0000);
        finish_cycle("post_rst_a");
        gnt_i = 1'b1;
        settle();
        check("post_rst_gnt", 64'(gnt_o), 64'b01);
        finish_cycle("post_rst_b");

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            rand_fields();
            rst_ni = ($urandom_range(0, 99) != 0);
            req_i  = N'($urandom);
            if (lock_m) req_i[idx_t'(lidx_m)] = 1'b1;
            gnt_i     = ($urandom_range(0, 3) != 0);
            r_valid_i = (q_m.size() > 0) && ($urandom_range(0, 1) == 1);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
